// File: rtl/dm_pkg.sv
// dm_pkg: definitions shared by the data-memory datapath, the decoder and the
// access arbiter.
//   - DM_* : access-type codes on the DMType / mem_type bus
//   - ST_* : arbiter FSM state encoding
//   - dm_bytes() : number of bytes touched by an access type
package dm_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  // The legality check is done in IDLE during the accept cycle, so no
  // separate CHECK state is needed.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  function automatic logic [2:0] dm_bytes(input logic [2:0] dm_type);
    case (dm_type)
      DM_WORD:            return 3'd4;
      DM_HALF, DM_HALF_U: return 3'd2;
      default:            return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   valid[1:0]  in   request lines (bit N = port N)
//   last_grant  in   port that was served most recently
//   grant[1:0]  out  one-hot grant, all zero when nothing is valid
// On a tie the port that was not served last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid[0] && (!valid[1] || last_grant)) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: shares the byte-addressed data memory between the CPU
// load/store unit (port 0) and the debug/DMA loader (port 1). One access per
// grant: legality check on accept, one memory command, one response pulse.
//   clk, rstn                    clock, asynchronous active-low reset
//   reqN_valid/ready/wr/addr/wdata/type   request port N (ready only in IDLE)
//   rspN_valid/rdata/err         single-cycle response to port N
//   mem_en/we/addr/wdata/type    memory command (mem_* hold while mem_en=0)
//   mem_rdata                    memory read data, already sign/zero extended
module dm_access_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_wr,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [31:0]       req0_wdata,
  input  logic [2:0]        req0_type,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_wr,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [31:0]       req1_wdata,
  input  logic [2:0]        req1_type,
  output logic              rsp0_valid,
  output logic [31:0]       rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_rdata,
  output logic              rsp1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_type,
  input  logic [31:0]       mem_rdata
);

  logic [1:0]        state;
  logic              last_grant;
  logic [1:0]        grant;
  logic              accept;
  logic              sel;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [2:0]        sel_type;
  logic              illegal;
  logic [ADDR_W:0]   end_addr;

  // request latches
  logic              port_q;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        type_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [2:0]        cnt;

  // last command actually sent, so mem_* stay stable between commands
  logic              we_hold;
  logic [ADDR_W-1:0] addr_hold;
  logic [31:0]       wdata_hold;
  logic [2:0]        type_hold;

  rr_arb2 u_rr_arb2 (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept     = (state == ST_IDLE) && (grant != 2'b00);
  // Gated by rstn so nothing is accepted while reset is held.
  assign req0_ready = rstn && accept && grant[0];
  assign req1_ready = rstn && accept && grant[1];

  assign sel       = grant[1];
  assign sel_wr    = sel ? req1_wr    : req0_wr;
  assign sel_addr  = sel ? req1_addr  : req0_addr;
  assign sel_wdata = sel ? req1_wdata : req0_wdata;
  assign sel_type  = sel ? req1_type  : req0_type;

  // Last byte touched must not pass the top of memory (no wrap-around).
  assign end_addr = {1'b0, sel_addr} + (ADDR_W+1)'(dm_bytes(sel_type) - 3'd1);

  always_comb begin
    illegal = 1'b0;
    if (sel_type > DM_BYTE_U)                                   illegal = 1'b1;
    if ((sel_type == DM_WORD) && (sel_addr[1:0] != 2'b00))      illegal = 1'b1;
    if (((sel_type == DM_HALF) || (sel_type == DM_HALF_U)) && sel_addr[0])
                                                                illegal = 1'b1;
    if (sel_wr && ((sel_type == DM_HALF_U) || (sel_type == DM_BYTE_U)))
                                                                illegal = 1'b1;
    if (end_addr[ADDR_W])                                       illegal = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      port_q     <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      type_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      cnt        <= '0;
      we_hold    <= 1'b0;
      addr_hold  <= '0;
      wdata_hold <= '0;
      type_hold  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            port_q  <= sel;
            wr_q    <= sel_wr;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            type_q  <= sel_type;
            err_q   <= illegal;
            rdata_q <= '0;
            state   <= illegal ? ST_RESP : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          we_hold    <= wr_q;
          addr_hold  <= addr_q;
          wdata_hold <= wdata_q;
          type_hold  <= type_q;
          cnt        <= '0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // Count MEM_LAT cycles after the first WAIT cycle, then sample;
          // the memory holds its read data until the next command.
          if (cnt == 3'(MEM_LAT)) begin
            if (!wr_q) rdata_q <= mem_rdata;
            state <= ST_RESP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_RESP: begin
          last_grant <= port_q;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_en    = (state == ST_ISSUE);
  assign mem_we    = mem_en ? wr_q    : we_hold;
  assign mem_addr  = mem_en ? addr_q  : addr_hold;
  assign mem_wdata = mem_en ? wdata_q : wdata_hold;
  assign mem_type  = mem_en ? type_q  : type_hold;

  assign rsp0_valid = (state == ST_RESP) && !port_q;
  assign rsp1_valid = (state == ST_RESP) &&  port_q;
  assign rsp0_rdata = rsp0_valid ? rdata_q : 32'h0;
  assign rsp1_rdata = rsp1_valid ? rdata_q : 32'h0;
  assign rsp0_err   = rsp0_valid && err_q;
  assign rsp1_err   = rsp1_valid && err_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb_dm_access_arbiter: directed test of dm_access_arbiter with a small
// behavioural data memory (MEM_LAT = 1, read data held until next command).
module tb_dm_access_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req0_ready, req0_wr;
  logic [5:0]  req0_addr;
  logic [31:0] req0_wdata;
  logic [2:0]  req0_type;
  logic        req1_valid, req1_ready, req1_wr;
  logic [5:0]  req1_addr;
  logic [31:0] req1_wdata;
  logic [2:0]  req1_type;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [2:0]  mem_type;

  dm_access_arbiter #(.ADDR_W(6), .MEM_LAT(1)) dut (
    .clk(clk), .rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_type(req0_type),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_type(req1_type),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_type(mem_type), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural memory ----------------
  logic [7:0] mem [0:63];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata[7:0];
        if (mem_type == 3'b000 || mem_type == 3'b001) mem[mem_addr+1] <= mem_wdata[15:8];
        if (mem_type == 3'b000) begin
          mem[mem_addr+2] <= mem_wdata[23:16];
          mem[mem_addr+3] <= mem_wdata[31:24];
        end
      end else begin
        case (mem_type)
          3'b000:  mem_rdata <= {mem[mem_addr+3], mem[mem_addr+2], mem[mem_addr+1], mem[mem_addr]};
          3'b001:  mem_rdata <= {{16{mem[mem_addr+1][7]}}, mem[mem_addr+1], mem[mem_addr]};
          3'b010:  mem_rdata <= {16'h0, mem[mem_addr+1], mem[mem_addr]};
          3'b011:  mem_rdata <= {{24{mem[mem_addr][7]}}, mem[mem_addr]};
          default: mem_rdata <= {24'h0, mem[mem_addr]};
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0;
  int rsp_seen = 0, rsp_cyc = 0, rsp_port = 0, both_cnt = 0, men_cnt = 0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  int grant_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_en) men_cnt++;
    if (rsp0_valid && rsp1_valid) both_cnt++;
    if (req0_valid && req0_ready) grant_q.push_back(0);
    if (req1_valid && req1_ready) grant_q.push_back(1);
    if (rsp0_valid || rsp1_valid) begin
      rsp_seen++;
      rsp_cyc   = cyc;
      rsp_port  = rsp1_valid ? 1 : 0;
      rsp_rdata = rsp1_valid ? rsp1_rdata : rsp0_rdata;
      rsp_err   = rsp1_valid ? rsp1_err : rsp0_err;
      $display("rsp port=%0d rdata=%08h err=%0b cycle=%0d", rsp_port, rsp_rdata, rsp_err, cyc);
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0, n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_val({tag, "_ctrl"},
              {24'h0, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_err, rsp1_err, mem_en, mem_we}, 32'h0);
    check_val({tag, "_rdata0"}, rsp0_rdata, 32'h0);
    check_val({tag, "_rdata1"}, rsp1_rdata, 32'h0);
    check_val({tag, "_memaddr"}, {26'h0, mem_addr}, 32'h0);
    check_val({tag, "_memwdata"}, mem_wdata, 32'h0);
    check_val({tag, "_memtype"}, {29'h0, mem_type}, 32'h0);
  endtask

  task automatic drive(input int port, input logic v, input logic wr,
                       input logic [5:0] a, input logic [31:0] wd, input logic [2:0] ty);
    if (port == 0) begin
      req0_valid = v; req0_wr = wr; req0_addr = a; req0_wdata = wd; req0_type = ty;
    end else begin
      req1_valid = v; req1_wr = wr; req1_addr = a; req1_wdata = wd; req1_type = ty;
    end
  endtask

  // One transaction; checks port, rdata, err, latency and mem_en pulses.
  task automatic xact(input string tag, input int port, input logic wr, input logic [5:0] a,
                      input logic [31:0] wd, input logic [2:0] ty,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int acc = 0, seen0, men0;
    bit got = 0;
    seen0 = rsp_seen;
    men0  = men_cnt;
    drive(port, 1'b1, wr, a, wd, ty);
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) begin
        got = 1;
        acc = cyc;
      end
    end
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, 6'h0, 32'h0, 3'h0);
    if (!got) begin
      check_val({tag, "_accept_timeout"}, 32'(got), 32'h1);
      return;
    end
    for (int i = 0; i < 40 && rsp_seen == seen0; i++) begin
      @(posedge clk); #2;
    end
    if (rsp_seen == seen0) begin
      check_val({tag, "_rsp_timeout"}, 32'(rsp_seen - seen0), 32'h1);
      return;
    end
    check_val({tag, "_port"},  32'(rsp_port), 32'(port));
    check_val({tag, "_rdata"}, rsp_rdata, exp_rdata);
    check_val({tag, "_err"},   {31'h0, rsp_err}, {31'h0, exp_err});
    check_val({tag, "_lat"},   32'(rsp_cyc - acc), 32'(exp_lat));
    check_val({tag, "_mem_en"}, 32'(men_cnt - men0), exp_err ? 32'h0 : 32'h1);
  endtask

  // Both ports hold valid continuously; expect grants alternating from first_port.
  task automatic contend(input string tag, input int n, input int first_port);
    int seen0, g0;
    seen0 = rsp_seen;
    g0 = grant_q.size();
    drive(0, 1'b1, 1'b0, 6'h04, 32'h0, 3'b000);
    drive(1, 1'b1, 1'b0, 6'h10, 32'h0, 3'b011);
    for (int i = 0; i < 200 && (grant_q.size() - g0) < n; i++) @(posedge clk);
    @(negedge clk);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 6'h0, 32'h0, 3'h0);
    drive(1, 1'b0, 1'b0, 6'h0, 32'h0, 3'h0);
    repeat (8) @(posedge clk);
    #2;
    check_val({tag, "_ngrants"}, 32'(grant_q.size() - g0), 32'(n));
    for (int k = 0; k < n && (g0 + k) < grant_q.size(); k++)
      check_val($sformatf("%s_grant%0d", tag, k), 32'(grant_q[g0 + k]), 32'((first_port + k) % 2));
    check_val({tag, "_nrsp"}, 32'(rsp_seen - seen0), 32'(n));
    check_val({tag, "_both_rsp"}, 32'(both_cnt), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem_rdata = 32'h0;
    rstn = 1'b0;
    drive(0, 1'b0, 1'b0, 6'h0, 32'h0, 3'h0);
    drive(1, 1'b0, 1'b0, 6'h0, 32'h0, 3'h0);
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // store then load a word
    xact("st_word",  0, 1'b1, 6'h04, 32'hDEADBEEF, 3'b000, 32'h0,        1'b0, 4);
    xact("ld_word",  0, 1'b0, 6'h04, 32'h0,        3'b000, 32'hDEADBEEF, 1'b0, 4);
    // misaligned half on port 1: error in one cycle, no memory command
    xact("ld_half_mis", 1, 1'b0, 6'h05, 32'h0, 3'b001, 32'h0, 1'b1, 1);
    // tie-break: port 0 first, then strict alternation
    contend("tie", 4, 0);
    // illegal encodings and boundaries
    xact("bad_type",  0, 1'b0, 6'h00, 32'h0, 3'b110, 32'h0, 1'b1, 1);
    xact("st_byte_u", 0, 1'b1, 6'h10, 32'h5A, 3'b100, 32'h0, 1'b1, 1);
    xact("word_3e",   0, 1'b0, 6'h3E, 32'h0, 3'b000, 32'h0, 1'b1, 1);
    xact("word_3c",   1, 1'b0, 6'h3C, 32'h0, 3'b000, 32'h0, 1'b0, 4);
    // sign / zero extension
    xact("st_byte",   0, 1'b1, 6'h10, 32'h00000080, 3'b011, 32'h0,        1'b0, 4);
    xact("ld_byte",   0, 1'b0, 6'h10, 32'h0,        3'b011, 32'hFFFFFF80, 1'b0, 4);
    xact("ld_byte_u", 1, 1'b0, 6'h10, 32'h0,        3'b100, 32'h00000080, 1'b0, 4);
    xact("ld_half",   0, 1'b0, 6'h06, 32'h0,        3'b001, 32'hFFFFDEAD, 1'b0, 4);
    xact("ld_half_u", 1, 1'b0, 6'h06, 32'h0,        3'b010, 32'h0000DEAD, 1'b0, 4);

    // reset while in WAIT: everything drops at once, no response afterwards
    begin
      int seen0;
      bit got = 0;
      seen0 = rsp_seen;
      drive(0, 1'b1, 1'b0, 6'h04, 32'h0, 3'b000);
      for (int i = 0; i < 40 && !got; i++) begin
        @(negedge clk);
        if (req0_ready) got = 1;
      end
      check_val("abort_accept", 32'(got), 32'h1);
      @(posedge clk); #1;               // now in ISSUE
      drive(0, 1'b0, 1'b0, 6'h0, 32'h0, 3'h0);
      @(posedge clk); #1;               // now in WAIT
      rstn = 1'b0;
      #1;
      check_quiet("abort");
      repeat (2) @(posedge clk);
      @(negedge clk) rstn = 1'b1;
      repeat (6) @(posedge clk);
      #2;
      check_val("abort_no_rsp", 32'(rsp_seen - seen0), 32'h0);
    end
    xact("post_rst", 1, 1'b0, 6'h04, 32'h0, 3'b000, 32'hDEADBEEF, 1'b0, 4);
    contend("post_tie", 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
